// File: rtl/ceespu_pkg.sv
// ceespu_pkg: shared definitions for the ceespu multiply/divide unit.
//   - MD_* : I_op encodings of ceespu_muldiv
//   - md_state_e : sequencing FSM states
//   - is_div_op() / is_rem_op() / is_signed_div() : op decode helpers
package ceespu_pkg;

  localparam logic [2:0] MD_MUL   = 3'd0;
  localparam logic [2:0] MD_MULH  = 3'd1;
  localparam logic [2:0] MD_MULHU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_REM   = 3'd5;
  localparam logic [2:0] MD_REMU  = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } md_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ceespu_divider.sv
// ceespu_divider: radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
//   I_clk, I_rst     : clock, synchronous active-high reset
//   I_start          : load operands and begin (WIDTH iterations follow)
//   I_dividend       : dividend magnitude
//   I_divisor        : divisor magnitude
//   O_done           : one-cycle pulse after the last iteration
//   O_quotient       : quotient magnitude, valid with O_done
//   O_remainder      : remainder magnitude, valid with O_done
module ceespu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [WIDTH-1:0] I_dividend,
  input  logic [WIDTH-1:0] I_divisor,
  output logic             O_done,
  output logic [WIDTH-1:0] O_quotient,
  output logic [WIDTH-1:0] O_remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0]  cnt_q;
  logic             active_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Partial remainder shifted left with the next dividend bit; diff MSB set means it was smaller
  // than the divisor and the subtraction must be discarded.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (I_start) begin
        quo_q    <= I_dividend;
        rem_q    <= '0;
        dvs_q    <= I_divisor;
        cnt_q    <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign O_done      = done_q;
  assign O_quotient  = quo_q;
  assign O_remainder = rem_q;

endmodule

// File: rtl/ceespu_muldiv.sv
// ceespu_muldiv: multi-cycle multiply/divide unit for the ceespu execute stage.
//   I_clk, I_rst        : clock, synchronous active-high reset
//   I_start             : launch request, accepted when O_busy is low
//   I_op                : operation (MD_* in ceespu_pkg), sampled on the accepting edge
//   I_dataA, I_dataB    : operands / dividend, divisor, sampled on the accepting edge
//   O_busy              : operation in flight
//   O_dataReady         : one-cycle result strobe
//   O_result            : result, held until the next O_dataReady
module ceespu_muldiv
  import ceespu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [2:0]       I_op,
  input  logic [WIDTH-1:0] I_dataA,
  input  logic [WIDTH-1:0] I_dataB,
  output logic             O_busy,
  output logic             O_dataReady,
  output logic [WIDTH-1:0] O_result
);

  localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  md_state_e          state_q, state_d;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               accept;

  // Operation context captured on the accepting edge.
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic             b_zero_q, ovf_q, q_neg_q, r_neg_q;

  assign accept = I_start && ((state_q == StIdle) || (state_q == StDone));

  // ---------------- Multiply ----------------
  // Operands are sign/zero-extended and multiplied modulo 2^(2*WIDTH); this keeps exactly the
  // low and high words of the WIDTH+1-bit extended product, which is all that is ever selected.
  logic             mul_signed;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_prod, mul_last;
  logic [2:0]       mul_op;
  logic [WIDTH-1:0] mul_result;

  assign mul_signed = (I_op == MD_MULH);
  assign mul_a_ext  = {{WIDTH{mul_signed & I_dataA[WIDTH-1]}}, I_dataA};
  assign mul_b_ext  = {{WIDTH{mul_signed & I_dataB[WIDTH-1]}}, I_dataB};
  assign mul_prod   = mul_a_ext * mul_b_ext;

  // Free-running register chain behind the multiplier; synthesis may retime it into the DSP.
  if (MUL_STAGES == 1) begin : g_mul_comb
    assign mul_last = mul_prod;
    assign mul_op   = I_op;
  end else begin : g_mul_pipe
    logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge I_clk) begin
      if (I_rst) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= mul_prod;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_last = pipe_q[MUL_STAGES-2];
    assign mul_op   = op_q;
  end

  assign mul_result = ((mul_op == MD_MULH) || (mul_op == MD_MULHU)) ?
                      mul_last[2*WIDTH-1:WIDTH] : mul_last[WIDTH-1:0];

  // ---------------- Divide ----------------
  // The accepting edge doubles as the setup cycle: magnitudes go straight into the core.
  logic             div_signed, a_neg, b_neg, div_start, div_done;
  logic [WIDTH-1:0] a_mag, b_mag, div_quo, div_rem;
  logic [WIDTH-1:0] fix_quo, fix_rem, div_result;

  assign div_signed = is_signed_div(I_op);
  assign a_neg      = div_signed & I_dataA[WIDTH-1];
  assign b_neg      = div_signed & I_dataB[WIDTH-1];
  assign a_mag      = a_neg ? -I_dataA : I_dataA;
  assign b_mag      = b_neg ? -I_dataB : I_dataB;
  assign div_start  = accept && is_div_op(I_op);

  ceespu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_start    (div_start),
    .I_dividend (a_mag),
    .I_divisor  (b_mag),
    .O_done     (div_done),
    .O_quotient (div_quo),
    .O_remainder(div_rem)
  );

  always_comb begin
    fix_quo = q_neg_q ? -div_quo : div_quo;
    fix_rem = r_neg_q ? -div_rem : div_rem;
    if (b_zero_q) begin
      fix_quo = '1;
      fix_rem = a_q;
    end else if (ovf_q) begin
      fix_quo = a_q;
      fix_rem = '0;
    end
    div_result = is_rem_op(op_q) ? fix_rem : fix_quo;
  end

  // ---------------- Sequencing ----------------
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (I_start) begin
          if (is_div_op(I_op)) begin
            state_d = StDiv;
          end else if (MUL_STAGES == 1) begin
            state_d  = StDone;
            result_d = mul_result;
          end else begin
            state_d   = StMul;
            mul_cnt_d = '0;
          end
        end
      end
      StMul: begin
        // The accepting edge is the first multiply stage, so StMul lasts MUL_STAGES-1 cycles.
        if (mul_cnt_q == MulCntW'(MUL_STAGES - 2)) begin
          state_d  = StDone;
          result_d = mul_result;
        end else begin
          mul_cnt_d = mul_cnt_q + MulCntW'(1);
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d  = StDone;
          result_d = div_result;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= StIdle;
      mul_cnt_q <= '0;
      result_q  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_zero_q  <= 1'b0;
      ovf_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      result_q  <= result_d;
      if (accept) begin
        op_q     <= I_op;
        a_q      <= I_dataA;
        b_zero_q <= (I_dataB == '0);
        ovf_q    <= div_signed && (I_dataA == {1'b1, {(WIDTH-1){1'b0}}}) && (I_dataB == '1);
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
      end
    end
  end

  assign O_busy      = (state_q == StMul) || (state_q == StDiv);
  assign O_dataReady = (state_q == StDone);
  assign O_result    = result_q;

endmodule

// File: tb/tb_ceespu_muldiv.sv
// Bench for ceespu_muldiv (WIDTH=32, MUL_STAGES=3). Stimulus pushes expected result and
// strobe cycle into a scoreboard; a negedge monitor pops and compares on every O_dataReady.
module tb_ceespu_muldiv;
  import ceespu_pkg::*;

  localparam int unsigned LMUL = 3;
  localparam int unsigned LDIV = 34;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_start;
  logic [2:0]  I_op;
  logic [31:0] I_dataA;
  logic [31:0] I_dataB;
  logic        O_busy;
  logic        O_dataReady;
  logic [31:0] O_result;

  ceespu_muldiv #(
    .WIDTH     (32),
    .MUL_STAGES(3)
  ) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_start    (I_start),
    .I_op       (I_op),
    .I_dataA    (I_dataA),
    .I_dataB    (I_dataB),
    .O_busy     (O_busy),
    .O_dataReady(O_dataReady),
    .O_result   (O_result)
  );

  always #5 I_clk = ~I_clk;

  int unsigned cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];
  int unsigned exp_cyc_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge I_clk) begin
    if (O_dataReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: got dataReady at cycle %0d, required none", cyc);
      end else begin
        logic [31:0] e;
        int unsigned ec;
        string       n;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        n  = name_q.pop_front();
        check({n, "_result"}, O_result, e);
        check({n, "_cycle"}, cyc, ec);
        check({n, "_busy_low"}, {31'd0, O_busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; start is held for one cycle, then operands are scrambled.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int unsigned lat,
                       input bit expect_result);
    I_start = 1'b1;
    I_op    = op;
    I_dataA = a;
    I_dataB = b;
    if (expect_result) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + lat);
      name_q.push_back(name);
    end
    @(negedge I_clk);
    I_start = 1'b0;
    I_op    = 3'd2;
    I_dataA = 32'hDEAD_BEEF;
    I_dataB = 32'h1234_5678;
  endtask

  // Returns at the negedge of the strobe cycle.
  task automatic wait_ready(input string name, input int limit, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < limit; i++) begin
      if (O_dataReady === 1'b1) return;
      if (O_busy === 1'b1) busy_cnt++;
      @(negedge I_clk);
    end
    checks++;
    fails++;
    $display("FAIL %s_timeout: got no dataReady within %0d cycles, required one", name, limit);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int          bc;
    int unsigned lat;
    lat = is_div_op(op) ? LDIV : LMUL;
    issue(name, op, a, b, exp, lat, 1'b1);
    wait_ready(name, int'(lat) + 10, bc);
    @(negedge I_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    I_rst   = 1'b1;
    I_start = 1'b0;
    I_op    = 3'd0;
    I_dataA = '0;
    I_dataB = '0;
    repeat (3) @(negedge I_clk);
    I_rst = 1'b0;
    check("reset_busy", {31'd0, O_busy}, 32'd0);
    check("reset_ready", {31'd0, O_dataReady}, 32'd0);
    check("reset_result", O_result, 32'd0);
    @(negedge I_clk);

    // MUL with strobe latency and busy width
    issue("mul_neg", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LMUL, 1'b1);
    wait_ready("mul_neg", 20, bc);
    check("mul_busy_cycles", bc, 32'd2);
    @(negedge I_clk);

    run("mulh_min",    MD_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu_max",   MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mul_op7",     3'd7,     32'd3,         32'd5,         32'd15);
    run("mulh_mixed",  MD_MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    run("mulhu_mixed", MD_MULHU, 32'hFFFF_FFFE, 32'd3,         32'd2);
    run("div_neg_a",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run("rem_neg_a",   MD_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run("div_neg_b",   MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run("rem_neg_b",   MD_REM,   32'd7,         32'hFFFF_FFFE, 32'd1);
    run("divu_big",    MD_DIVU,  32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run("remu_big",    MD_REMU,  32'hFFFF_FFF9, 32'd2,         32'd1);
    run("divu_by0",    MD_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF);
    run("remu_by0",    MD_REMU,  32'd5,         32'd0,         32'd5);
    run("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",     MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("div_by0",     MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run("rem_by0",     MD_REM,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);

    // Start while busy is ignored
    issue("divu_ignore", MD_DIVU, 32'd100, 32'd7, 32'd14, LDIV, 1'b1);
    repeat (9) @(negedge I_clk);
    check("busy_mid_div", {31'd0, O_busy}, 32'd1);
    I_start = 1'b1;
    I_op    = MD_MUL;
    I_dataA = 32'd6;
    I_dataB = 32'd6;
    @(negedge I_clk);
    I_start = 1'b0;
    wait_ready("divu_ignore", 40, bc);
    @(negedge I_clk);

    // Back-to-back starts in the DONE cycle
    issue("b2b_first", MD_MUL, 32'd2, 32'd3, 32'd6, LMUL, 1'b1);
    wait_ready("b2b_first", 20, bc);
    issue("b2b_second", MD_MUL, 32'd4, 32'd5, 32'd20, LMUL, 1'b1);
    wait_ready("b2b_second", 20, bc);
    issue("b2b_div", MD_DIVU, 32'd9, 32'd2, 32'd4, LDIV, 1'b1);
    wait_ready("b2b_div", 50, bc);
    @(negedge I_clk);

    // Reset at cycle 20 of a divide aborts it
    issue("aborted", MD_DIVU, 32'd100, 32'd7, 32'd0, LDIV, 1'b0);
    repeat (19) @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    I_rst = 1'b0;
    check("abort_busy", {31'd0, O_busy}, 32'd0);
    check("abort_ready", {31'd0, O_dataReady}, 32'd0);
    check("abort_result", O_result, 32'd0);
    repeat (40) @(negedge I_clk);
    run("mul_after_rst", MD_MUL, 32'd6, 32'd7, 32'd42);

    // Reset coincident with start: start dropped
    I_rst   = 1'b1;
    I_start = 1'b1;
    I_op    = MD_MUL;
    I_dataA = 32'd2;
    I_dataB = 32'd2;
    @(negedge I_clk);
    I_rst   = 1'b0;
    I_start = 1'b0;
    check("rst_start_busy", {31'd0, O_busy}, 32'd0);
    check("rst_start_result", O_result, 32'd0);
    repeat (6) @(negedge I_clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ceespu_muldiv.md
# ceespu_muldiv

Parametrised multi-cycle multiply/divide unit for the ceespu execute stage; takes multiply off the single-cycle ALU path and adds signed/unsigned high-word multiply plus divide and remainder. An operation is launched with a start pulse. The unit reports busy while working and pulses a ready strobe with the result. The pipeline stalls on `O_busy` and captures `O_result` on `O_dataReady`.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 8.
- `MUL_STAGES`, 3: multiply latency in cycles, ≥ 1. The multiplier is a retimeable inferred pipeline.
- `I_clk`  in  1  clock, all state on rising edge.
- `I_rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `I_start`  in  1  launch request; accepted only when `O_busy`=0.
- `I_op`  in  3  operation, sampled on the accepting edge.
- `I_dataA`  in  WIDTH  operand A / dividend, sampled on the accepting edge.
- `I_dataB`  in  WIDTH  operand B / divisor, sampled on the accepting edge.
- `O_busy`  out  1  operation in flight; new starts are ignored.
- `O_dataReady`  out  1  one-cycle pulse; `O_result` is valid in this cycle.
- `O_result`  out  WIDTH  result; holds its value until the next `O_dataReady`.

## Operation
- `I_op` encodings:
  - 0 MUL: low WIDTH bits of A×B.
  - 1 MULH: high WIDTH bits, signed×signed.
  - 2 MULHU: high WIDTH bits, unsigned×unsigned.
  - 3 DIV: signed quotient, truncated toward zero.
  - 4 DIVU: unsigned quotient.
  - 5 REM: signed remainder; its sign follows the dividend.
  - 6 REMU: unsigned remainder.
  - 7: treated as MUL.
- Multiply: operands are extended to WIDTH+1 bits according to signedness, so the product is 2·WIDTH+2 bits. Select the low or high WIDTH bits of that product.
- Divide: radix-2 restoring divider, one quotient bit per cycle, operating on magnitudes.
  - Setup cycle: take absolute values and record the result sign.
  - WIDTH iteration cycles.
  - Fixup cycle: apply the sign and handle special cases.
- Divide special cases, resolved in the fixup cycle with no change in latency:
  - B=0: quotient = all ones; remainder = A.
  - DIV/REM with A=−2^(WIDTH−1) and B=−1: quotient = A; remainder = 0.
- FSM states:
  - IDLE: start with a MUL op → MUL; start with a DIV op → DIV.
  - MUL: counts MUL_STAGES cycles → DONE.
  - DIV: setup, then WIDTH iterations, then fixup → DONE.
  - DONE: lasts one cycle, with `O_dataReady`=1 and `O_busy`=0. A start in this cycle is accepted (back-to-back); otherwise → IDLE.
- `O_busy` = (state is MUL or DIV).
- `I_start` while `O_busy`=1 is ignored: no queuing, no effect on the operation in flight. Operand changes after the accepting edge have no effect.

## Timing
- Latency L is counted from the accepting edge t0. `O_dataReady` is high in the cycle after edge t0+L.
  - MUL ops: L = MUL_STAGES.
  - DIV ops: L = WIDTH+2.
- With the defaults, MUL L = 3 and DIV L = 34.
- `O_busy` rises in the cycle after t0 and falls in the same cycle `O_dataReady` rises.
- Back-to-back throughput: one MUL every MUL_STAGES cycles; one DIV every WIDTH+2 cycles.
- Reset values: state IDLE, `O_busy`=0, `O_dataReady`=0, `O_result`=0, counters 0, pipeline registers 0.
- Reset during MUL or DIV aborts the operation: no `O_dataReady` pulse is produced and `O_result` is cleared.
- Reset coincident with `I_start`: reset wins and the start is dropped.

## Structure
- Shared package `ceespu_pkg`:
  - op encoding constants `MD_MUL` … `MD_REMU`.
  - FSM state typedef.
  - helper `is_div_op()`.
- Sub-module `ceespu_divider`, parametrised by WIDTH: magnitude-only iterative core with its own start/done, quotient/remainder outputs and a bit counter.
- Top level holds the FSM, sign handling, special-case fixup and the multiply pipeline, inline so the multiply infers DSP blocks.

## Test plan
- MUL, A=7, B=0xFFFFFFFD → `O_result`=0xFFFFFFEB; `O_dataReady` exactly 3 cycles after start; `O_busy` high for 2 cycles.
- High-word multiply:
  - MULH, 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, A=0xFFFFFFF9 (−7), B=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - `O_dataReady` exactly 34 cycles after start in both cases.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Handshake:
  - Start DIVU 100/7, then pulse `I_start` with a MUL at cycle 10 → MUL ignored; result 14 at cycle 34.
  - Start in the DONE cycle → accepted; second result 3 cycles later.
- Reset at cycle 20 of a DIV → no `O_dataReady`; `O_result`=0 and `O_busy`=0 after the reset edge; the next MUL 6×7 returns 42 with normal latency.
